// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU control path:
//   - 4-bit opcode constants (IR[31:28])
//   - ALU operation, PC source and write-back source encodings
//   - controller state enum and the coarse opcode class used for sequencing
// No ports; imported by ctrl_decode and multicycle_ctrl.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes, in ISA order
  localparam logic [3:0] ALU_LW    = 4'd0;
  localparam logic [3:0] ALU_SW    = 4'd1;
  localparam logic [3:0] ALU_LI    = 4'd2;
  localparam logic [3:0] ALU_ADDU  = 4'd3;
  localparam logic [3:0] ALU_ADDIU = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_MUL   = 4'd6;
  localparam logic [3:0] ALU_BGE   = 4'd7;
  localparam logic [3:0] ALU_J     = 4'd8;
  localparam logic [3:0] ALU_MULI  = 4'd9;

  // ALU operations
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_BGE = 3'b011;

  // PC source select
  localparam logic [1:0] PC_SRC_STEP   = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Register-file write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_MUL = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MULW,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  // Where an opcode goes after DECODE/EXEC
  typedef enum logic [1:0] {
    CLS_ALU,     // EXEC then WB (ADDU, ADDIU, SLL, LI)
    CLS_MEM,     // EXEC then MEM (LW, SW)
    CLS_BRANCH,  // retires in EXEC (BGE, J)
    CLS_MUL      // MULW then WB (MUL, MULI)
  } op_class_t;

  // Opcodes above MULI are unassigned
  function automatic logic is_illegal(input logic [3:0] op);
    return op > ALU_MULI;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Combinational opcode/state decoder for multicycle_ctrl.
// Ports:
//   state     in   current controller state
//   op        in   latched opcode (IR[31:28])
//   alu_op    out  ALU operation (meaningful in EXEC and MULW)
//   alu_src_b out  ALU operand B: 0 = rt, 1 = sign-extended immediate
//   wb_sel    out  write-back source (meaningful in WB)
//   op_class  out  sequencing class of the opcode
//   illegal   out  opcode is unassigned
// -----------------------------------------------------------------------------
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t      state,
  input  logic [3:0]  op,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output op_class_t   op_class,
  output logic        illegal
);

  always_comb begin
    op_class  = CLS_ALU;
    alu_op    = OP_ADD;
    alu_src_b = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = is_illegal(op);

    case (op)
      ALU_LW, ALU_SW:    op_class = CLS_MEM;
      ALU_MUL, ALU_MULI: op_class = CLS_MUL;
      ALU_BGE, ALU_J:    op_class = CLS_BRANCH;
      default:           op_class = CLS_ALU;
    endcase

    // Datapath selects are only driven in the states that use them so that
    // IDLE and TRAP present an all-zero control word.
    case (state)
      S_EXEC: begin
        case (op)
          ALU_LW, ALU_SW, ALU_ADDIU: alu_src_b = 1'b1;
          ALU_SLL: begin
            alu_op    = OP_SLL;
            alu_src_b = 1'b1;
          end
          ALU_BGE: alu_op = OP_BGE;
          default: ;
        endcase
      end
      S_MULW: begin
        alu_op    = OP_MUL;
        alu_src_b = (op == ALU_MULI);
      end
      S_WB: begin
        case (op)
          ALU_LW:            wb_sel = WB_MEM;
          ALU_LI:            wb_sel = WB_IMM;
          ALU_MUL, ALU_MULI: wb_sel = WB_MUL;
          default:           wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control FSM (fetch/decode/execute/memory/write-back) for the
// 4-bit-opcode CPU datapath.
// Parameters:
//   PC_STEP      PC increment applied by the datapath when pc_src_o = 0
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset
//   run_i        run enable, sampled in IDLE and at instruction boundaries
//   mem_rdata_i  memory read data (instruction word during fetch)
//   mem_ack_i    memory access complete (pulse)
//   mul_done_i   multiplier result valid (pulse)
//   bge_taken_i  datapath comparison rs >= rt
//   mem_req_o    memory request; mem_we_o write qualifier; addr_sel_o 0=PC 1=ALU
//   ir_we_o      IR load; pc_we_o / pc_src_o PC load and source
//   alu_op_o     ALU op; alu_src_b_o operand B select
//   mul_start_o  multiplier start pulse
//   reg_we_o     register write; wb_sel_o write-back source
//   illegal_o    sticky illegal-opcode flag
//   retired_o    retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  input  logic        mul_done_i,
  input  logic        bge_taken_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_src_b_o,
  output logic        mul_start_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [31:0] retired_o
);

  state_t      state_reg;
  state_t      state_next;
  state_t      after_retire;
  logic [3:0]  op_q;
  logic        mul_first_reg;
  logic [31:0] retired_reg;
  logic        retire;
  op_class_t   op_class;
  logic        op_illegal;

  // Only the opcode field of the fetched word is interpreted here, and the PC
  // adder lives in the datapath; these are kept on the interface for it.
  logic unused_bits;
  assign unused_bits = ^{mem_rdata_i[27:0], 32'(PC_STEP)};

  ctrl_decode u_decode (
    .state     (state_reg),
    .op        (op_q),
    .alu_op    (alu_op_o),
    .alu_src_b (alu_src_b_o),
    .wb_sel    (wb_sel_o),
    .op_class  (op_class),
    .illegal   (op_illegal)
  );

  assign after_retire = run_i ? S_FETCH : S_IDLE;
  assign illegal_o    = (state_reg == S_TRAP);  // TRAP is only left by reset
  assign retired_o    = retired_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= S_IDLE;
      op_q          <= 4'd0;
      mul_first_reg <= 1'b0;
      retired_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (ir_we_o) begin
        op_q <= mem_rdata_i[31:28];
      end
      // Marks the first MULW cycle so the start strobe is a single pulse
      // however long the multiplier takes.
      mul_first_reg <= (state_next == S_MULW) && (state_reg != S_MULW);
      if (retire) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = PC_SRC_STEP;
    mul_start_o = 1'b0;
    reg_we_o    = 1'b0;
    retire      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run_i) state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o    = 1'b1;
          pc_we_o    = 1'b1;
          pc_src_o   = PC_SRC_STEP;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_illegal)                state_next = S_TRAP;
        else if (op_class == CLS_MUL)  state_next = S_MULW;
        else                           state_next = S_EXEC;
      end

      S_EXEC: begin
        case (op_class)
          CLS_MEM: state_next = S_MEM;
          CLS_BRANCH: begin
            retire     = 1'b1;
            state_next = after_retire;
            if (op_q == ALU_J) begin
              pc_we_o  = 1'b1;
              pc_src_o = PC_SRC_JUMP;
            end else if (bge_taken_i) begin
              pc_we_o  = 1'b1;
              pc_src_o = PC_SRC_BRANCH;
            end
          end
          default: state_next = S_WB;
        endcase
      end

      S_MULW: begin
        mul_start_o = mul_first_reg;
        // A done pulse in the entry cycle is accepted as well.
        if (mul_done_i) state_next = S_WB;
      end

      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (op_q == ALU_SW);
        if (mem_ack_i) begin
          if (op_q == ALU_SW) begin
            retire     = 1'b1;
            state_next = after_retire;
          end else begin
            state_next = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we_o   = 1'b1;
        retire     = 1'b1;
        state_next = after_retire;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Builds an instruction-level schedule (per-opcode phase list, random wait
// states, multiplier latency, run drops, spurious handshakes) into a per-cycle
// table of inputs and expected outputs, then replays it against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  // ISA opcodes
  localparam int LW = 0, SW = 1, LI = 2, ADDU = 3, ADDIU = 4, SLL = 5;
  localparam int MUL = 6, BGE = 7, J = 8, MULI = 9;

  // Phases (for messages and schedule edits)
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3;
  localparam int PH_MULW = 4, PH_MEM = 5, PH_WB = 6, PH_TRAP = 7, PH_RST = 8;

  // Observed control word bit map
  localparam logic [15:0] B_REQ  = 16'h8000;
  localparam logic [15:0] B_WE   = 16'h4000;
  localparam logic [15:0] B_ASEL = 16'h2000;
  localparam logic [15:0] B_IR   = 16'h1000;
  localparam logic [15:0] B_PCWE = 16'h0800;
  localparam logic [15:0] M_PCS  = 16'h0600;
  localparam logic [15:0] M_ALU  = 16'h01C0;
  localparam logic [15:0] B_SRCB = 16'h0020;
  localparam logic [15:0] B_MST  = 16'h0010;
  localparam logic [15:0] B_RWE  = 16'h0008;
  localparam logic [15:0] M_WB   = 16'h0006;
  localparam logic [15:0] B_ILL  = 16'h0001;
  localparam logic [15:0] FULL   = 16'hFFFF;

  typedef struct {
    logic        rst;
    logic        run;
    logic        ack;
    logic        mdone;
    logic        bge;
    logic [31:0] rdata;
    logic [15:0] exp;
    logic [15:0] mask;
    logic        retire;
    int          phase;
  } cyc_t;

  cyc_t trace[$];
  cyc_t ins[$];

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ack, mul_done, bge_taken;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, mul_start, reg_we, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.PC_STEP(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .run_i       (run),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .mul_done_i  (mul_done),
    .bge_taken_i (bge_taken),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .addr_sel_o  (addr_sel),
    .ir_we_o     (ir_we),
    .pc_we_o     (pc_we),
    .pc_src_o    (pc_src),
    .alu_op_o    (alu_op),
    .alu_src_b_o (alu_src_b),
    .mul_start_o (mul_start),
    .reg_we_o    (reg_we),
    .wb_sel_o    (wb_sel),
    .illegal_o   (illegal),
    .retired_o   (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic string phase_name(input int ph);
    case (ph)
      PH_IDLE:   return "idle";
      PH_FETCH:  return "fetch";
      PH_DECODE: return "decode";
      PH_EXEC:   return "exec";
      PH_MULW:   return "mulw";
      PH_MEM:    return "mem";
      PH_WB:     return "wb";
      PH_TRAP:   return "trap";
      default:   return "reset";
    endcase
  endfunction

  function automatic logic [15:0] f_pcs(input int v); return 16'(v) << 9; endfunction
  function automatic logic [15:0] f_alu(input int v); return 16'(v) << 6; endfunction
  function automatic logic [15:0] f_wb(input int v);  return 16'(v) << 1; endfunction
  function automatic logic sp();  return ($urandom_range(0, 3) == 0); endfunction
  function automatic logic rb();  return 1'($urandom_range(0, 1)); endfunction

  task automatic push(input int ph, input logic ack, input logic md, input logic bge,
                      input logic [31:0] rd, input logic [15:0] exp,
                      input logic [15:0] mask, input logic ret);
    cyc_t c;
    c.rst = 1'b1; c.run = 1'b1; c.ack = ack; c.mdone = md; c.bge = bge;
    c.rdata = rd; c.exp = exp; c.mask = mask; c.retire = ret; c.phase = ph;
    ins.push_back(c);
  endtask

  task automatic push_idle(input logic run_v);
    push(PH_IDLE, sp(), sp(), rb(), $urandom, 16'h0, FULL, 1'b0);
    ins[ins.size()-1].run = run_v;
  endtask

  task automatic push_reset(input logic [15:0] exp, input logic [15:0] mask);
    push(PH_RST, 1'b0, 1'b0, 1'b0, 32'h0, exp, mask, 1'b0);
    ins[ins.size()-1].rst = 1'b0;
    ins[ins.size()-1].run = 1'b0;
  endtask

  task automatic flush();
    foreach (ins[i]) trace.push_back(ins[i]);
    ins.delete();
  endtask

  // One instruction: wf/wm = fetch/data wait cycles, mlat = MULW cycles,
  // drop_at = cycle index from which run_i is low (-1 none, -2 random).
  task automatic add_instr(input int op, input int wf, input int wm, input int mlat,
                           input logic bge_t, input int drop_at, input logic rst_in_mem);
    logic [31:0] word;
    logic [15:0] e;
    logic [15:0] m;
    int          drop;
    word = {op[3:0], 28'($urandom)};
    ins.delete();

    for (int i = 0; i < wf; i++)
      push(PH_FETCH, 1'b0, sp(), rb(), $urandom, B_REQ, ~(M_ALU | M_WB | M_PCS), 1'b0);
    push(PH_FETCH, 1'b1, sp(), rb(), word, B_REQ | B_IR | B_PCWE, ~(M_ALU | M_WB), 1'b0);
    push(PH_DECODE, sp(), sp(), rb(), $urandom, 16'h0, ~(M_ALU | M_WB | M_PCS), 1'b0);

    if (op > MULI) begin
      for (int i = 0; i < 100; i++)
        push(PH_TRAP, sp(), sp(), rb(), $urandom, B_ILL, ~(M_ALU | B_SRCB | M_WB | M_PCS), 1'b0);
      push_reset(B_ILL, ~(M_ALU | B_SRCB | M_WB | M_PCS));
      push_idle(1'b0);
      flush();
      return;
    end

    if (op == MUL || op == MULI) begin
      for (int i = 0; i < mlat; i++) begin
        if (i == 0) begin
          e = B_MST | f_alu(1) | ((op == MULI) ? B_SRCB : 16'h0);
          m = ~(M_WB | M_PCS);
        end else begin
          e = 16'h0;
          m = ~(M_ALU | B_SRCB | M_WB | M_PCS);
        end
        push(PH_MULW, sp(), (i == mlat - 1), rb(), $urandom, e, m, 1'b0);
      end
      push(PH_WB, sp(), sp(), rb(), $urandom, B_RWE | f_wb(2), ~(M_ALU | B_SRCB | M_PCS), 1'b1);
    end else begin
      m = ~(M_WB | M_PCS);
      case (op)
        LW, SW, ADDIU: e = f_alu(0) | B_SRCB;
        ADDU:          e = f_alu(0);
        SLL:           e = f_alu(2) | B_SRCB;
        LI: begin e = 16'h0; m = ~(M_ALU | B_SRCB | M_WB | M_PCS); end
        BGE: begin
          e = f_alu(3) | (bge_t ? (B_PCWE | f_pcs(1)) : 16'h0);
          m = ~(B_SRCB | M_WB | (bge_t ? 16'h0 : M_PCS));
        end
        default: begin e = B_PCWE | f_pcs(2); m = ~(M_ALU | B_SRCB | M_WB); end
      endcase
      if (op == BGE)
        push(PH_EXEC, sp(), sp(), bge_t, $urandom, e, m, 1'b1);
      else
        push(PH_EXEC, sp(), sp(), rb(), $urandom, e, m, (op == J));

      if (op == LW || op == SW) begin
        e = B_REQ | B_ASEL | ((op == SW) ? B_WE : 16'h0);
        m = ~(M_ALU | B_SRCB | M_WB | M_PCS);
        for (int i = 0; i < wm; i++)
          push(PH_MEM, 1'b0, sp(), rb(), $urandom, e, m, 1'b0);
        push(PH_MEM, 1'b1, sp(), rb(), $urandom, e, m, (op == SW));
      end
      if (op == LW || op == LI || op == ADDU || op == ADDIU || op == SLL)
        push(PH_WB, sp(), sp(), rb(), $urandom,
             B_RWE | f_wb((op == LW) ? 1 : ((op == LI) ? 3 : 0)),
             ~(M_ALU | B_SRCB | M_PCS), 1'b1);
    end

    if (rst_in_mem) begin
      for (int i = 0; i < ins.size(); i++) begin
        if (ins[i].phase == PH_MEM) begin
          ins[i].rst = 1'b0;
          ins[i].ack = 1'b0;
          while (ins.size() > i + 1) void'(ins.pop_back());
          break;
        end
      end
      push_idle(1'b0);
      push_idle(1'b1);
      flush();
      return;
    end

    drop = drop_at;
    if (drop == -2)
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ins.size() - 1)) : -1;
    if (drop >= 0) begin
      for (int i = drop; i < ins.size(); i++) ins[i].run = 1'b0;
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) push_idle(1'b0);
      push_idle(1'b1);
    end
    flush();
  endtask

  initial begin
    logic [15:0] obs;
    logic [31:0] model_cnt;
    cyc_t        c;

    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mul_done = 1'b0;
    bge_taken = 1'b0; mem_rdata = 32'h0;
    model_cnt = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state, then release with run high
    push_reset(16'h0, FULL);
    push_reset(16'h0, FULL);
    push_idle(1'b0);
    push_idle(1'b1);
    flush();

    add_instr(ADDU, 0, 0, 1, 1'b0, -1, 1'b0);
    add_instr(LW,   3, 3, 1, 1'b0, -1, 1'b0);
    add_instr(BGE,  0, 0, 1, 1'b1, -1, 1'b0);
    add_instr(BGE,  0, 0, 1, 1'b0, -1, 1'b0);
    add_instr(MULI, 0, 0, 5, 1'b0, -1, 1'b0);
    add_instr(MUL,  1, 0, 1, 1'b0, -1, 1'b0);
    add_instr(ADDIU, 0, 0, 1, 1'b0, 2, 1'b0);   // run drops in EXEC

    for (int n = 0; n < 40; n++)
      add_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                rb(), -2, 1'b0);

    add_instr(SW, 0, 2, 1, 1'b0, -1, 1'b1);     // reset during MEM of SW
    add_instr(J,  1, 0, 1, 1'b0, -1, 1'b0);
    add_instr(11, 0, 0, 1, 1'b0, -1, 1'b0);     // illegal opcode 0xB

    for (int i = 0; i < trace.size(); i++) begin
      c = trace[i];
      @(posedge clk);
      #1;
      rst_n = c.rst; run = c.run; mem_ack = c.ack; mul_done = c.mdone;
      bge_taken = c.bge; mem_rdata = c.rdata;
      #4;
      obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op,
             alu_src_b, mul_start, reg_we, wb_sel, illegal};
      check_eq($sformatf("%s ctrl cyc%0d", phase_name(c.phase), i),
               32'(obs & c.mask), 32'(c.exp & c.mask));
      check_eq($sformatf("%s retired cyc%0d", phase_name(c.phase), i), retired, model_cnt);
      if (!c.rst)        model_cnt = 32'd0;
      else if (c.retire) model_cnt = model_cnt + 32'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
